// File: rtl/pe_pkg.sv
// Shared types for the PE weight-load path.
// Holds the sequencer state encoding.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } pe_wls_state_e;

endpackage

// File: rtl/pe_weight_load_sequencer.sv
// Streams a burst of weight words into a PE register bank,
// driving binary write address/enable for pe_binary_decoder.
module pe_weight_load_sequencer
  import pe_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAXLEN = DEPTH[ADDR_WIDTH:0];

  pe_wls_state_e state;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] len_c;
  logic beat;
  logic last;

  // Oversized lengths load the whole bank once.
  assign len_c = (len > MAXLEN) ? MAXLEN : len;

  assign in_ready = (state == LOAD) && !abort;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && !abort;
  assign beat     = in_valid && in_ready;
  assign last     = ((cnt + 1'b1) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            len_q <= len_c;
            cnt   <= '0;
            state <= (len_c == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (beat) begin
            wr_en   <= 1'b1;
            wr_addr <= cnt[ADDR_WIDTH-1:0];
            wr_data <= in_data;
            cnt     <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_weight_load_sequencer.sv
// Self-checking bench for pe_weight_load_sequencer:
// vector table, directed corner sequences, random vs. model.
module tb_pe_weight_load_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [2:0] wr_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  pe_weight_load_sequencer #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_addr(wr_addr), .wr_en(wr_en),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [3:0] ln;
    logic       ab;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       en;
    logic [2:0] a;
    logic [7:0] wd;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic st, logic [3:0] ln, logic ab, logic v, logic [7:0] d,
    logic rdy, logic en, logic [2:0] a, logic [7:0] wd,
    logic bsy, logic dn);
    vec_t r;
    r.st = st; r.ln = ln; r.ab = ab; r.v = v; r.d = d;
    r.rdy = rdy; r.en = en; r.a = a; r.wd = wd;
    r.bsy = bsy; r.dn = dn;
    return r;
  endfunction

  task automatic chk(string n, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic rdy, logic en,
                         logic [2:0] a, logic [7:0] wd,
                         logic bsy, logic dn);
    chk({tag, ".in_ready"}, in_ready, rdy);
    chk({tag, ".wr_en"}, wr_en, en);
    chk({tag, ".wr_addr"}, wr_addr, a);
    chk({tag, ".wr_data"}, wr_data, wd);
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".done"}, done, dn);
  endtask

  task automatic drive(logic st, logic [3:0] ln, logic ab,
                       logic v, logic [7:0] d);
    @(negedge clk);
    start = st; len = ln; abort = ab; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; abort = 0; in_valid = 0; in_data = 0; len = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state: phase 0 idle, 1 load, 2 done.
  int m_phase;
  int m_got;
  int m_target;
  logic [2:0] m_addr;
  logic [7:0] m_data;
  logic m_en;

  task automatic model_step(logic st, logic [3:0] ln, logic ab,
                            logic v, logic [7:0] d);
    m_en = 1'b0;
    case (m_phase)
      0: if (st && !ab) begin
        m_target = (ln > 8) ? 8 : int'(ln);
        m_got = 0;
        m_phase = (m_target == 0) ? 2 : 1;
      end
      1: if (ab) m_phase = 0;
         else if (v) begin
           m_en = 1'b1;
           m_addr = 3'(m_got);
           m_data = d;
           m_got++;
           if (m_got == m_target) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    // Idle with valid, len=3 with gaps, len=0, abort, restart.
    tbl.push_back(mk(0,0,0,1,8'h55, 0,0,0,8'h00, 0,0));
    tbl.push_back(mk(0,0,0,1,8'h56, 0,0,0,8'h00, 0,0));
    tbl.push_back(mk(1,3,0,0,8'h00, 1,0,0,8'h00, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hA1, 1,1,0,8'hA1, 1,0));
    tbl.push_back(mk(1,7,0,0,8'hEE, 1,0,0,8'hA1, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hA2, 1,1,1,8'hA2, 1,0));
    tbl.push_back(mk(0,0,0,0,8'h00, 1,0,1,8'hA2, 1,0));
    tbl.push_back(mk(0,0,0,0,8'h00, 1,0,1,8'hA2, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hA3, 0,1,2,8'hA3, 1,1));
    tbl.push_back(mk(0,0,0,1,8'hA4, 0,0,2,8'hA3, 0,0));
    tbl.push_back(mk(1,0,0,0,8'h00, 0,0,2,8'hA3, 1,1));
    tbl.push_back(mk(0,0,0,1,8'h00, 0,0,2,8'hA3, 0,0));
    tbl.push_back(mk(1,5,1,0,8'h00, 0,0,2,8'hA3, 0,0));
    tbl.push_back(mk(1,5,0,0,8'h00, 1,0,2,8'hA3, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hB0, 1,1,0,8'hB0, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hB1, 1,1,1,8'hB1, 1,0));
    tbl.push_back(mk(0,0,1,1,8'hB2, 0,0,1,8'hB1, 0,0));
    tbl.push_back(mk(0,0,0,1,8'hB3, 0,0,1,8'hB1, 0,0));
    tbl.push_back(mk(1,1,0,0,8'h00, 1,0,1,8'hB1, 1,0));
    tbl.push_back(mk(0,0,0,1,8'hC0, 0,1,0,8'hC0, 1,1));
    tbl.push_back(mk(0,0,0,0,8'h00, 0,0,0,8'hC0, 0,0));

    do_reset();
    #1;
    chk_all("reset", 0, 0, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ln, tbl[i].ab, tbl[i].v, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en,
              tbl[i].a, tbl[i].wd, tbl[i].bsy, tbl[i].dn);
    end

    // Full bank, continuous stream.
    drive(1, 8, 0, 0, 0);
    chk_all("full.start", 1, 0, 0, 8'hC0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 8'(8'h10 + i));
      chk_all($sformatf("full.b%0d", i), (i != 7), 1, 3'(i),
              8'(8'h10 + i), 1, (i == 7));
    end
    drive(0, 0, 0, 1, 8'h99);
    chk_all("full.end", 0, 0, 7, 8'h17, 0, 0);

    // Clamp: len 12 writes exactly 8 words.
    drive(1, 12, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 8'(8'h20 + i));
    chk_all("clamp.last", 0, 1, 7, 8'h27, 1, 1);
    drive(0, 0, 0, 1, 8'h77);
    chk_all("clamp.end", 0, 0, 7, 8'h27, 0, 0);

    // Asynchronous reset between edges mid-burst.
    drive(1, 8, 0, 0, 0);
    drive(0, 0, 0, 1, 8'h31);
    drive(0, 0, 0, 1, 8'h32);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2, 0, 0, 0);
    chk_all("post_rst.start", 1, 0, 0, 8'h00, 1, 0);
    drive(0, 0, 0, 1, 8'h41);
    chk_all("post_rst.b0", 1, 1, 0, 8'h41, 1, 0);
    drive(0, 0, 0, 1, 8'h42);
    chk_all("post_rst.b1", 0, 1, 1, 8'h42, 1, 1);
    drive(0, 0, 0, 0, 0);
    chk_all("post_rst.end", 0, 0, 1, 8'h42, 0, 0);

    // Random traffic against the transaction-level model.
    do_reset();
    m_phase = 0; m_got = 0; m_target = 0;
    m_addr = 0; m_data = 0; m_en = 0;
    for (int c = 0; c < 600; c++) begin
      logic st, ab, v;
      logic [3:0] ln;
      logic [7:0] d;
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 2) != 0);
      ln = 4'($urandom_range(0, 15));
      d  = 8'($urandom);
      model_step(st, ln, ab, v, d);
      drive(st, ln, ab, v, d);
      chk_all($sformatf("rnd%0d", c), (m_phase == 1) && !ab, m_en,
              m_addr, m_data, (m_phase != 0), (m_phase == 2) && !ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
